// File: rtl/gsram_pkg.sv
// Shared definitions for the gSRAM tile sequencer.
//   GS_ROWS / GS_COLS : default array geometry (10x10)
//   GS_MODE_*         : command mode encoding sampled with start
//   gs_state_e        : sequencer state encoding
package gsram_pkg;

  localparam int unsigned GS_ROWS = 10;
  localparam int unsigned GS_COLS = 10;

  localparam logic [1:0] GS_MODE_LUT = 2'b00;
  localparam logic [1:0] GS_MODE_M2  = 2'b01;
  localparam logic [1:0] GS_MODE_RD  = 2'b10;
  localparam logic [1:0] GS_MODE_ILL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StDrain,
    StDone
  } gs_state_e;

endpackage

// File: rtl/gsram_ctrl_if.sv
// Tile-side bus of the gSRAM sequencer: write-source handshake, tile address/control pins and
// the tagged read stream.
//   master : the sequencer (drives tile pins, src_ready and the read tags)
//   slave  : the tile / data source side
interface gsram_ctrl_if;

  logic       src_valid;
  logic       src_ready;
  logic       sram_we;
  logic [3:0] sram_row;
  logic [3:0] sram_col;
  logic       sram_inmuxsel;
  logic       rd_valid;
  logic [3:0] rd_row;
  logic [3:0] rd_col;

  modport master (
    input  src_valid,
    output src_ready,
    output sram_we,
    output sram_row,
    output sram_col,
    output sram_inmuxsel,
    output rd_valid,
    output rd_row,
    output rd_col
  );

  modport slave (
    output src_valid,
    input  src_ready,
    input  sram_we,
    input  sram_row,
    input  sram_col,
    input  sram_inmuxsel,
    input  rd_valid,
    input  rd_row,
    input  rd_col
  );

endinterface

// File: rtl/gsram_addr_gen.sv
// Row-major row/column counter for the gSRAM tile.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to (0,0), takes priority over adv
//   adv        : step to the next element (col wraps into row+1)
//   row, col   : current registered address
//   last       : current address is (ROWS-1, COLS-1)
module gsram_addr_gen
  import gsram_pkg::*;
#(
  parameter int unsigned ROWS = GS_ROWS,
  parameter int unsigned COLS = GS_COLS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       last
);

  localparam logic [3:0] RowMax = 4'(ROWS - 1);
  localparam logic [3:0] ColMax = 4'(COLS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (clr) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (adv) begin
      if (col == ColMax) begin
        col <= 4'd0;
        row <= (row == RowMax) ? 4'd0 : row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
    end
  end

  assign last = (row == RowMax) && (col == ColMax);

endmodule

// File: rtl/gsram_ctrl.sv
// Sequencer for the gSRAM tile: one full row-major pass per command (LUT preload, M2 write-back
// or read-out scan).
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, mode     : command strobe and mode (sampled only in idle)
//   abort           : ends the current pass, no done pulse
//   bus (master)    : source handshake, tile we/row/col/inmuxsel, tagged read stream
//   busy, done, err : status (done/err are one-cycle pulses)
//   stall_cnt       : only with GSRAM_CTRL_STATS_EN, write cycles waiting on src_valid
module gsram_ctrl
  import gsram_pkg::*;
#(
  parameter int unsigned ROWS = GS_ROWS,
  parameter int unsigned COLS = GS_COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  gsram_ctrl_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef GSRAM_CTRL_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  gs_state_e  state;
  logic       inmuxsel_q;
  logic       rd_valid_q;
  logic [3:0] rd_row_q;
  logic [3:0] rd_col_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic [3:0] row;
  logic [3:0] col;
  logic       last;
  logic       accept;
  logic       in_wr;
  logic       in_rd;
  logic       hs;
  logic       adv;

  assign accept = (state == StIdle) && start && (mode != GS_MODE_ILL);
  assign in_wr  = (state == StWr);
  assign in_rd  = (state == StRd);
  // abort gates the tile strobe in the same cycle so nothing is written once it is seen
  assign hs     = in_wr && bus.src_valid && !abort;
  // Counter parks on the last element rather than wrapping back to (0,0)
  assign adv    = ((hs || (in_rd && !abort)) && !last);

  gsram_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .adv   (adv),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      inmuxsel_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_row_q   <= 4'd0;
      rd_col_q   <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            unique case (mode)
              GS_MODE_LUT: begin
                state      <= StWr;
                inmuxsel_q <= 1'b1;
                busy_q     <= 1'b1;
              end
              GS_MODE_M2: begin
                state      <= StWr;
                inmuxsel_q <= 1'b0;
                busy_q     <= 1'b1;
              end
              GS_MODE_RD: begin
                state  <= StRd;
                busy_q <= 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        StWr: begin
          if (abort) begin
            state  <= StIdle;
            busy_q <= 1'b0;
          end else if (hs && last) begin
            state  <= StDone;
            done_q <= 1'b1;
          end
        end
        StRd: begin
          if (abort) begin
            state  <= StIdle;
            busy_q <= 1'b0;
          end else begin
            // Tags trail the issued address by one cycle, matching the tile's registered read
            rd_valid_q <= 1'b1;
            rd_row_q   <= row;
            rd_col_q   <= col;
            if (last) begin
              state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            state  <= StIdle;
            busy_q <= 1'b0;
          end else begin
            state  <= StDone;
            done_q <= 1'b1;
          end
        end
        StDone: begin
          state  <= StIdle;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= StIdle;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef GSRAM_CTRL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else if (accept) begin
      stall_q <= 16'd0;
    end else if (in_wr && !abort && !bus.src_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign bus.src_ready     = in_wr && !abort;
  assign bus.sram_we       = hs;
  assign bus.sram_row      = row;
  assign bus.sram_col      = col;
  assign bus.sram_inmuxsel = inmuxsel_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_row        = rd_row_q;
  assign bus.rd_col        = rd_col_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule
